// File: rtl/pushbutton_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pushbutton_reader_pkg
//  Purpose  : Shared state encodings and types for the pushbutton reader.
//  Revision : 1.0  initial release
// ============================================================================
package pushbutton_reader_pkg;

    typedef logic [1:0] btn_state_t;

    // Debounce FSM encodings
    localparam btn_state_t c_ST_RELEASED   = 2'd0;
    localparam btn_state_t c_ST_DB_PRESS   = 2'd1;
    localparam btn_state_t c_ST_PRESSED    = 2'd2;
    localparam btn_state_t c_ST_DB_RELEASE = 2'd3;

endpackage : pushbutton_reader_pkg
`default_nettype wire

// File: rtl/pushbutton_reader_bit_sync.sv
`default_nettype none
// ============================================================================
//  Module   : bit_sync
//  Purpose  : Multi-flop synchroniser for a single asynchronous pad. The whole
//             chain resets to RST_VAL so no spurious edge appears at reset.
//  Revision : 1.0  initial release
// ============================================================================
module bit_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    // Shift the pad sample through the chain; index 0 is the metastable stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule : bit_sync
`default_nettype wire

// File: rtl/pushbutton_reader.sv
`default_nettype none
// ============================================================================
//  Module   : pushbutton_reader
//  Purpose  : Synchronises and debounces a user pushbutton; reports clean level,
//             press/release/long-press strobes, a short-press toggle and a
//             wrapping press counter. All outputs are registered.
//  Revision : 1.0  initial release
// ============================================================================
module pushbutton_reader
    import pushbutton_reader_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 240000,
    parameter int LONG_CNT     = 12000000,
    parameter int ACTIVE_LOW   = 1,
    parameter int CNT_W        = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       toggle,
    output logic [7:0] click_cnt
);

    // Pad level that means "not pressed"; also the synchroniser reset value
    localparam logic             c_IDLE_PAD = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] c_DB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] c_LG_LAST  = CNT_W'(LONG_CNT - 1);

    logic             w_sync;
    logic             w_s;
    logic             w_db_done;

    btn_state_t       r_state;
    btn_state_t       w_next_state;

    logic [CNT_W-1:0] r_db_cnt,     w_db_cnt_nxt;
    logic [CNT_W-1:0] r_hold_cnt,   w_hold_cnt_nxt;
    logic             r_long_fired, w_long_fired_nxt;
    logic             r_level,      w_level_nxt;
    logic             r_press,      w_press_nxt;
    logic             r_release,    w_release_nxt;
    logic             r_long,       w_long_nxt;
    logic             r_toggle,     w_toggle_nxt;
    logic [7:0]       r_click,      w_click_nxt;

    bit_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (c_IDLE_PAD)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (w_sync)
    );

    // Normalise polarity so w_s = 1 always means pressed
    assign w_s       = w_sync ^ c_IDLE_PAD;
    assign w_db_done = (r_db_cnt == c_DB_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_RELEASED;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: any contrary sample during debounce falls back
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_RELEASED:   if (w_s)            w_next_state = c_ST_DB_PRESS;
            c_ST_DB_PRESS:   if (!w_s)           w_next_state = c_ST_RELEASED;
                             else if (w_db_done) w_next_state = c_ST_PRESSED;
            c_ST_PRESSED:    if (!w_s)           w_next_state = c_ST_DB_RELEASE;
            c_ST_DB_RELEASE: if (w_s)            w_next_state = c_ST_PRESSED;
                             else if (w_db_done) w_next_state = c_ST_RELEASED;
            default:                             w_next_state = c_ST_RELEASED;
        endcase
    end

    // Output/datapath decode: next values of counters, flags and strobes
    always_comb begin
        w_db_cnt_nxt     = r_db_cnt;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_long_fired_nxt = r_long_fired;
        w_level_nxt      = r_level;
        w_press_nxt      = 1'b0;
        w_release_nxt    = 1'b0;
        w_long_nxt       = 1'b0;
        w_toggle_nxt     = r_toggle;
        w_click_nxt      = r_click;
        case (r_state)
            c_ST_RELEASED: begin
                if (w_s) w_db_cnt_nxt = '0;
            end
            c_ST_DB_PRESS: begin
                if (w_s) begin
                    if (w_db_done) begin
                        w_level_nxt      = 1'b1;
                        w_press_nxt      = 1'b1;
                        w_click_nxt      = r_click + 8'd1;
                        w_hold_cnt_nxt   = '0;
                        w_long_fired_nxt = 1'b0;
                    end else begin
                        w_db_cnt_nxt = r_db_cnt + 1'b1;
                    end
                end
            end
            c_ST_PRESSED: begin
                if (!w_s) begin
                    w_db_cnt_nxt = '0;
                end else begin
                    // Hold counter saturates so long_fired alone gates repeats
                    if (r_hold_cnt != c_LG_LAST) w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                    if ((r_hold_cnt == c_LG_LAST) && !r_long_fired) begin
                        w_long_nxt       = 1'b1;
                        w_long_fired_nxt = 1'b1;
                    end
                end
            end
            c_ST_DB_RELEASE: begin
                // hold_cnt is frozen here so a rejected bounce resumes the hold
                if (!w_s) begin
                    if (w_db_done) begin
                        w_level_nxt   = 1'b0;
                        w_release_nxt = 1'b1;
                        if (!r_long_fired) w_toggle_nxt = ~r_toggle;
                    end else begin
                        w_db_cnt_nxt = r_db_cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt     <= '0;
            r_hold_cnt   <= '0;
            r_long_fired <= 1'b0;
            r_level      <= 1'b0;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_long       <= 1'b0;
            r_toggle     <= 1'b0;
            r_click      <= 8'd0;
        end else begin
            r_db_cnt     <= w_db_cnt_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_long_fired <= w_long_fired_nxt;
            r_level      <= w_level_nxt;
            r_press      <= w_press_nxt;
            r_release    <= w_release_nxt;
            r_long       <= w_long_nxt;
            r_toggle     <= w_toggle_nxt;
            r_click      <= w_click_nxt;
        end
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;
    assign toggle        = r_toggle;
    assign click_cnt     = r_click;

endmodule : pushbutton_reader
`default_nettype wire

// File: tb/tb_pushbutton_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pushbutton_reader
//  Purpose  : Directed self-checking bench for pushbutton_reader
//             (SYNC_STAGES=2, DEBOUNCE_CNT=4, LONG_CNT=20, ACTIVE_LOW=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pushbutton_reader;

    logic       clk;
    logic       rst_n;
    logic       btn_in;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic       toggle;
    logic [7:0] click_cnt;

    int vectors;
    int miscompares;

    // Per-run observations gathered by run_edges
    int p_cnt, r_cnt, l_cnt, p_first, r_first, l_first, lvl_first, overlap;

    pushbutton_reader #(
        .SYNC_STAGES  (2),
        .DEBOUNCE_CNT (4),
        .LONG_CNT     (20),
        .ACTIVE_LOW   (1),
        .CNT_W        (24)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .toggle        (toggle),
        .click_cnt     (click_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, sampling 1 time unit after each edge.
    // Edge indices are 1-based relative to the start of the run.
    task automatic run_edges(input int n);
        p_cnt = 0; r_cnt = 0; l_cnt = 0; overlap = 0;
        p_first = 0; r_first = 0; l_first = 0; lvl_first = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (press_pulse)   begin p_cnt++; if (p_first == 0) p_first = i; end
            if (release_pulse) begin r_cnt++; if (r_first == 0) r_first = i; end
            if (long_pulse)    begin l_cnt++; if (l_first == 0) l_first = i; end
            if (btn_level && lvl_first == 0) lvl_first = i;
            if ((int'(press_pulse) + int'(release_pulse) + int'(long_pulse)) > 1) overlap++;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        btn_in = 1'b1;
        run_edges(3);
        vectors++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, toggle, click_cnt} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {btn_level, press_pulse, release_pulse, long_pulse, toggle, click_cnt});
        end
        rst_n = 1'b1;
        run_edges(5);
        vectors++;
        if ((p_cnt + r_cnt + l_cnt) != 0 || lvl_first != 0 || click_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_idle: got pulses %0d lvl_first %0d click %0d expected 0 0 0",
                     p_cnt + r_cnt + l_cnt, lvl_first, click_cnt);
        end
    endtask

    task automatic test_bounce();
        int tot;
        int lvl;
        btn_in = 1'b0; run_edges(3); tot = p_cnt + r_cnt + l_cnt; lvl = lvl_first;
        btn_in = 1'b1; run_edges(1); tot += p_cnt + r_cnt + l_cnt; lvl += lvl_first;
        btn_in = 1'b0; run_edges(3); tot += p_cnt + r_cnt + l_cnt; lvl += lvl_first;
        btn_in = 1'b1; run_edges(20); tot += p_cnt + r_cnt + l_cnt; lvl += lvl_first;
        vectors++;
        if (tot != 0) begin
            miscompares++;
            $display("FAIL bounce_pulses: got %0d expected 0", tot);
        end
        vectors++;
        if (lvl != 0 || btn_level !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce_level: got lvl_first_sum %0d level %b expected 0 0", lvl, btn_level);
        end
        vectors++;
        if (click_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL bounce_click: got %0d expected 0", click_cnt);
        end
    endtask

    task automatic test_clean_press();
        btn_in = 1'b0;
        run_edges(10);
        vectors++;
        if (p_first != 7 || p_cnt != 1) begin
            miscompares++;
            $display("FAIL press_timing: got edge %0d count %0d expected edge 7 count 1", p_first, p_cnt);
        end
        vectors++;
        if (lvl_first != 7 || btn_level !== 1'b1) begin
            miscompares++;
            $display("FAIL press_level: got first %0d level %b expected 7 1", lvl_first, btn_level);
        end
        vectors++;
        if (click_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL press_click: got %0d expected 1", click_cnt);
        end
        btn_in = 1'b1;
        run_edges(10);
        vectors++;
        if (r_first != 7 || r_cnt != 1 || p_cnt != 0 || l_cnt != 0 || overlap != 0) begin
            miscompares++;
            $display("FAIL release_timing: got edge %0d r %0d p %0d l %0d ov %0d expected 7 1 0 0 0",
                     r_first, r_cnt, p_cnt, l_cnt, overlap);
        end
        vectors++;
        if (toggle !== 1'b1 || btn_level !== 1'b0) begin
            miscompares++;
            $display("FAIL release_toggle: got toggle %b level %b expected 1 0", toggle, btn_level);
        end
    endtask

    task automatic test_long_press();
        btn_in = 1'b0;
        run_edges(37);
        vectors++;
        if (p_first != 7 || l_first != 27 || l_cnt != 1 || overlap != 0) begin
            miscompares++;
            $display("FAIL long_timing: got press %0d long %0d count %0d ov %0d expected 7 27 1 0",
                     p_first, l_first, l_cnt, overlap);
        end
        btn_in = 1'b1;
        run_edges(10);
        vectors++;
        if (r_cnt != 1 || p_cnt != 0 || l_cnt != 0) begin
            miscompares++;
            $display("FAIL long_release: got r %0d p %0d l %0d expected 1 0 0", r_cnt, p_cnt, l_cnt);
        end
        vectors++;
        if (toggle !== 1'b1 || click_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL long_toggle: got toggle %b click %0d expected 1 2", toggle, click_cnt);
        end
    endtask

    task automatic test_release_bounce();
        int rel;
        btn_in = 1'b0; run_edges(12);
        vectors++;
        if (p_first != 7) begin
            miscompares++;
            $display("FAIL rb_press: got edge %0d expected 7", p_first);
        end
        rel = r_cnt;
        btn_in = 1'b1; run_edges(2);  rel += r_cnt;
        btn_in = 1'b0; run_edges(30); rel += r_cnt;
        // Three edges spent outside PRESSED delay the long strobe from 27 to 30
        vectors++;
        if (l_first != 16 || l_cnt != 1) begin
            miscompares++;
            $display("FAIL rb_long: got edge %0d count %0d expected 16 1", l_first, l_cnt);
        end
        vectors++;
        if (rel != 0 || btn_level !== 1'b1) begin
            miscompares++;
            $display("FAIL rb_no_release: got releases %0d level %b expected 0 1", rel, btn_level);
        end
        btn_in = 1'b1; run_edges(10);
        vectors++;
        if (r_cnt != 1 || toggle !== 1'b1 || click_cnt !== 8'd3) begin
            miscompares++;
            $display("FAIL rb_end: got r %0d toggle %b click %0d expected 1 1 3", r_cnt, toggle, click_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int tp, tr, tl;
        tp = 0; tr = 0; tl = 0;
        for (int i = 0; i < 256; i++) begin
            btn_in = 1'b0; run_edges(9); tp += p_cnt; tr += r_cnt; tl += l_cnt;
            if (i == 252) begin
                vectors++;
                if (click_cnt !== 8'd0) begin
                    miscompares++;
                    $display("FAIL wrap_point: got %0d expected 0", click_cnt);
                end
            end
            btn_in = 1'b1; run_edges(9); tp += p_cnt; tr += r_cnt; tl += l_cnt;
        end
        vectors++;
        if (tp != 256 || tr != 256 || tl != 0) begin
            miscompares++;
            $display("FAIL wrap_pulses: got p %0d r %0d l %0d expected 256 256 0", tp, tr, tl);
        end
        vectors++;
        if (click_cnt !== 8'd3 || toggle !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_final: got click %0d toggle %b expected 3 1", click_cnt, toggle);
        end
    endtask

    task automatic test_async_reset();
        // Mid-debounce reset
        btn_in = 1'b0;
        run_edges(4);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({btn_level, toggle, click_cnt} !== 10'd0) begin
            miscompares++;
            $display("FAIL arst_db: got level %b toggle %b click %0d expected 0 0 0",
                     btn_level, toggle, click_cnt);
        end
        run_edges(3);
        vectors++;
        if ((p_cnt + r_cnt + l_cnt) != 0) begin
            miscompares++;
            $display("FAIL arst_db_quiet: got %0d pulses expected 0", p_cnt + r_cnt + l_cnt);
        end
        // Pad still low when reset releases: fresh press after sync + debounce
        rst_n = 1'b1;
        run_edges(12);
        vectors++;
        if (p_first != 7 || p_cnt != 1 || click_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL arst_fresh_press: got edge %0d count %0d click %0d expected 7 1 1",
                     p_first, p_cnt, click_cnt);
        end
        // Mid-hold reset
        run_edges(5);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({btn_level, toggle, click_cnt} !== 10'd0) begin
            miscompares++;
            $display("FAIL arst_hold: got level %b toggle %b click %0d expected 0 0 0",
                     btn_level, toggle, click_cnt);
        end
        run_edges(3);
        btn_in = 1'b1;
        rst_n  = 1'b1;
        run_edges(30);
        vectors++;
        if ((p_cnt + r_cnt + l_cnt) != 0 || lvl_first != 0) begin
            miscompares++;
            $display("FAIL arst_hold_quiet: got pulses %0d lvl_first %0d expected 0 0",
                     p_cnt + r_cnt + l_cnt, lvl_first);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        btn_in      = 1'b1;
        test_reset();
        test_bounce();
        test_clean_press();
        test_long_press();
        test_release_bounce();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pushbutton_reader
`default_nettype wire
